// File: rtl/ycfg_pkg.sv
// ycfg_pkg: shared FSM encoding and counter width helper for the config loader
package ycfg_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ycfg_loader_if.sv
// ycfg_loader_if: host-side control, write and readback handshakes of the loader
interface ycfg_loader_if #(parameter int W = 8);

    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] wr_data;
    logic         wr_valid;
    logic         wr_ready;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         rd_ready;

    modport master (
        output start, wr_data, wr_valid, rd_ready,
        input  busy, done, wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  start, wr_data, wr_valid, rd_ready,
        output busy, done, wr_ready, rd_data, rd_valid
    );

endinterface

// File: rtl/ycfg_phase_timer.sv
// ycfg_phase_timer: DIV-cycle down-counter timing each confclk half-period
module ycfg_phase_timer import ycfg_pkg::*; #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tc
);

    localparam int TW = cw(DIV + 1);

    logic [TW-1:0] cnt;

    // load on phase entry so tc rises in the phase's DIV-th cycle
    always_ff @(posedge clk)
        if (reset) cnt <= '0;
        else if (load) cnt <= TW'(DIV - 1);
        else if (cnt != '0) cnt <= cnt - 1'b1;

    assign tc = cnt == '0;

endmodule

// File: rtl/ycfg_loader.sv
// ycfg_loader: serializes host words into a ycell config chain and returns the bits shifted out
module ycfg_loader import ycfg_pkg::*; #(
    parameter int W     = 8,
    parameter int NBITS = 48,
    parameter int DIV   = 2
) (
    input  logic          clk,
    input  logic          reset,
    ycfg_loader_if.slave  h,
    output logic          confclk,
    output logic          cbitin,
    input  logic          cbitout
);

    localparam int NW  = NBITS / W;
    localparam int BW  = cw(W);
    localparam int WCW = cw(NW + 1);

    if (NBITS % W != 0 || DIV < 1 || W < 2) begin : g_param_check
        $error("ycfg_loader: NBITS must be a multiple of W, DIV >= 1, W >= 2");
    end

    logic [2:0]     state;
    logic [W-1:0]   tx;
    logic [W-1:0]   rx;
    logic [BW-1:0]  bidx;
    logic [WCW-1:0] wcnt;
    logic           tc;
    logic           accept;
    logic           last_bit;
    logic           last_word;
    logic           rd_fire;
    logic           in_bit;

    assign accept    = state == S_LOAD && h.wr_valid;
    assign in_bit    = state == S_SETUP || state == S_HIGH;
    assign last_bit  = bidx == BW'(W - 1);
    assign last_word = wcnt == WCW'(NW);
    assign rd_fire   = state == S_FLUSH && h.rd_ready;

    ycfg_phase_timer #(.DIV(DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (accept || (in_bit && tc)),
        .tc    (tc)
    );

    // pass sequencing; waits in LOAD/FLUSH stall the chain without a strobe
    always_ff @(posedge clk)
        if (reset) state <= S_IDLE;
        else unique case (state)
            S_IDLE:  if (h.start) state <= S_LOAD;
            S_LOAD:  if (h.wr_valid) state <= S_SETUP;
            S_SETUP: if (tc) state <= S_HIGH;
            S_HIGH:  if (tc) state <= last_bit ? S_FLUSH : S_SETUP;
            S_FLUSH: if (h.rd_ready) state <= last_word ? S_IDLE : S_LOAD;
            default: state <= S_IDLE;
        endcase

    // shift registers, bit/word counters and the end-of-pass pulse
    always_ff @(posedge clk)
        if (reset) begin
            tx     <= '0;
            rx     <= '0;
            bidx   <= '0;
            wcnt   <= '0;
            h.done <= 1'b0;
        end else begin
            h.done <= rd_fire && last_word;
            if (state == S_IDLE && h.start) wcnt <= '0;
            if (accept) begin
                tx   <= h.wr_data;
                bidx <= '0;
                wcnt <= wcnt + 1'b1;
            end
            if (state == S_SETUP && tc) rx <= {rx[W-2:0], cbitout};
            if (state == S_HIGH && tc) begin
                tx <= tx << 1;
                if (!last_bit) bidx <= bidx + 1'b1;
            end
        end

    assign h.busy     = state != S_IDLE;
    assign h.wr_ready = state == S_LOAD;
    assign h.rd_valid = state == S_FLUSH;
    assign h.rd_data  = rx;
    assign confclk    = state == S_HIGH;
    assign cbitin     = in_bit && tx[W-1];

endmodule

// File: tb/tb_ycfg_loader.sv
// tb_ycfg_loader: randomized scoreboard bench with a bit-queue chain model
module tb_ycfg_loader;

    localparam int W     = 8;
    localparam int NBITS = 48;
    localparam int DIV   = 2;
    localparam int NW    = NBITS / W;
    localparam int NB2   = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ycfg_loader_if #(.W(W)) h ();
    ycfg_loader_if #(.W(W)) h2 ();

    logic confclk, cbitin, cbitout;
    logic confclk2, cbitin2, cbitout2;
    logic [NBITS-1:0] chain  = '0;
    logic [NB2-1:0]   chain2 = '0;

    always @(posedge confclk) chain <= {chain[NBITS-2:0], cbitin};
    always @(posedge confclk2) chain2 <= {chain2[NB2-2:0], cbitin2};
    assign cbitout  = chain[NBITS-1];
    assign cbitout2 = chain2[NB2-1];

    ycfg_loader #(.W(W), .NBITS(NBITS), .DIV(DIV)) dut (
        .clk(clk), .reset(reset), .h(h), .confclk(confclk), .cbitin(cbitin), .cbitout(cbitout)
    );

    ycfg_loader #(.W(W), .NBITS(NB2), .DIV(1)) dut2 (
        .clk(clk), .reset(reset), .h(h2), .confclk(confclk2), .cbitin(cbitin2), .cbitout(cbitout2)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: chain contents as a bit queue, front = next bit to leave
    bit             mq[$];
    bit             snap[$];
    bit             strm[$];
    logic [W-1:0]   exp_q[$];

    task automatic accept_model(input logic [W-1:0] w);
        logic [W-1:0] e;
        for (int i = 0; i < W; i++) e[W-1-i] = mq.pop_front();
        exp_q.push_back(e);
        for (int i = 0; i < W; i++) begin
            mq.push_back(w[W-1-i]);
            strm.push_back(w[W-1-i]);
        end
    endtask

    task automatic chain_chk();
        logic [63:0] e;
        e = '0;
        for (int i = 0; i < NBITS; i++) e[NBITS-1-i] = mq[i];
        chk("chain_contents", {16'b0, chain}, e);
    endtask

    function automatic logic [63:0] outs1();
        return {50'b0, h.busy, h.done, h.wr_ready, h.rd_valid, confclk, cbitin, h.rd_data};
    endfunction

    // monitor: strobe count/period, readback scoreboard, stall stability
    int npulse = 0, cyc = 0, last_rise = 0, wbit = 0;
    logic pcf = 1'b0, hold = 1'b0;
    logic [W-1:0] held = '0;
    always @(negedge clk) begin
        cyc++;
        if (confclk && !pcf) begin
            npulse++;
            if (wbit != 0) chk("confclk_period", 64'(cyc - last_rise), 64'(2 * DIV));
            last_rise = cyc;
            wbit = (wbit + 1) % W;
        end
        pcf = confclk;
        if (reset) begin
            wbit = 0;
            hold = 1'b0;
        end else begin
            if (hold && h.rd_valid) chk("rd_data_stable", 64'(h.rd_data), 64'(held));
            if (h.rd_valid && h.rd_ready) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL readback_unexpected: got %0h with nothing required", h.rd_data);
                end else chk("readback", 64'(h.rd_data), 64'(exp_q.pop_front()));
            end
            hold = h.rd_valid && !h.rd_ready;
            held = h.rd_data;
        end
    end

    // readback host: immediate, fixed-stall or random rd_ready
    int fl = 0;
    int rd_stall = 0;
    bit rd_rand = 1'b0;
    initial begin
        h.rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fl = h.rd_valid ? fl + 1 : 0;
            h.rd_ready = rd_rand ? 1'($urandom_range(0, 1)) : (fl > rd_stall);
        end
    end

    // DIV=1 instance monitor
    int r2 = 0, d2 = 0, lr2 = 0, wb2 = 0, c2 = 0;
    logic p2 = 1'b0;
    always @(negedge clk) begin
        c2++;
        if (confclk2 && !p2) begin
            r2++;
            if (wb2 != 0) chk("div1_period", 64'(c2 - lr2), 64'd2);
            lr2 = c2;
            wb2 = (wb2 + 1) % W;
        end
        p2 = confclk2;
        if (h2.done) d2++;
    end

    task automatic do_abort(input int ab);
        int n;
        logic pc;
        n = 0;
        pc = 1'b1;
        while (!(confclk && !pc && npulse == ab - 1) && n < 1000) begin
            pc = confclk;
            @(posedge clk);
            #1;
            n++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_mid_outputs", outs1(), 64'd0);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("abort_pulses", 64'(npulse), 64'(ab));
        chk("abort_idle", {63'b0, h.busy}, 64'd0);
        mq = snap;
        repeat (ab) void'(mq.pop_front());
        for (int j = 0; j < ab; j++) mq.push_back(strm[j]);
        exp_q.delete();
    endtask

    task automatic run_pass(input logic [W-1:0] ws[NW], input int wstall, input int abort);
        int n, p0;
        snap = mq;
        strm.delete();
        npulse = 0;
        h.start = 1'b1;
        @(posedge clk);
        #1;
        h.start = 1'b0;
        chk("load_after_start", {62'b0, h.busy, h.wr_ready}, 64'd3);
        for (int i = 0; i < NW; i++) begin
            n = 0;
            while (!h.wr_ready && n < 500) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (!h.wr_ready) begin
                chk("wr_ready_timeout", {63'b0, h.wr_ready}, 64'd1);
                return;
            end
            if (wstall > 0) begin
                p0 = npulse;
                repeat (wstall) begin
                    @(posedge clk);
                    #1;
                end
                chk("stall_no_pulse", 64'(npulse - p0), 64'd0);
                chk("stall_load", {62'b0, confclk, h.wr_ready}, 64'd1);
            end
            h.wr_data = ws[i];
            h.wr_valid = 1'b1;
            @(posedge clk);
            #1;
            h.wr_valid = 1'b0;
            accept_model(ws[i]);
            chk("cbitin_msb", {62'b0, confclk, cbitin}, {62'b0, 1'b0, ws[i][W-1]});
            if (abort > 0 && (i + 1) * W >= abort) begin
                do_abort(abort);
                return;
            end
            n = 0;
            while (!h.rd_valid && n < 1000) begin
                h.wr_valid = 1'($urandom);
                h.wr_data = W'($urandom);
                @(posedge clk);
                #1;
                n++;
            end
            h.wr_valid = 1'b0;
            chk("rd_valid_latency", 64'(n), 64'(2 * DIV * W));
        end
        n = 0;
        while (!h.done && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_pulse", {63'b0, h.done}, 64'd1);
        chk("busy_at_done", {63'b0, h.busy}, 64'd0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", {63'b0, h.done}, 64'd0);
        chk("pulse_count", 64'(npulse), 64'(NBITS));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] wa[NW];
        logic [W-1:0] wb[NW];
        logic [W-1:0] wr[NW];
        for (int i = 0; i < NBITS; i++) mq.push_back(1'b0);
        h.start = 1'b1;
        h.wr_valid = 1'b0;
        h.wr_data = '0;
        h2.start = 1'b0;
        h2.wr_valid = 1'b1;
        h2.wr_data = 8'hC3;
        h2.rd_ready = 1'b1;
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset_outputs", outs1(), 64'd0);
        end
        reset = 1'b0;
        h.start = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_idle", {62'b0, h.busy, h.wr_ready}, 64'd0);
        chk("no_pulse_in_reset", 64'(npulse), 64'd0);

        wa = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
        run_pass(wa, 0, 0);
        chk("chain_pattern_a", {16'b0, chain}, 64'hA53CFF00817E);
        chain_chk();

        wb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_pass(wb, 0, 0);
        chain_chk();

        foreach (wr[i]) wr[i] = W'($urandom);
        rd_stall = 7;
        run_pass(wr, 5, 0);
        rd_stall = 0;
        chain_chk();

        foreach (wr[i]) wr[i] = W'($urandom);
        rd_rand = 1'b1;
        run_pass(wr, 0, 0);
        rd_rand = 1'b0;
        chain_chk();

        foreach (wr[i]) wr[i] = W'($urandom);
        run_pass(wr, 0, 19);
        chain_chk();

        foreach (wr[i]) wr[i] = W'($urandom);
        run_pass(wr, 0, 0);
        chain_chk();

        h2.start = 1'b1;
        @(posedge clk);
        #1;
        h2.start = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            h2.start = h2.busy && (i % 3 == 0);
        end
        h2.start = 1'b0;
        chk("div1_done_count", 64'(d2), 64'd1);
        chk("div1_pulse_count", 64'(r2), 64'(NB2));
        chk("div1_idle", {63'b0, h2.busy}, 64'd0);
        chk("div1_chain", {48'b0, chain2}, 64'hC3C3);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
